// File: rtl/stop_watch_pkg.sv
// rtl/stop_watch_pkg.sv - shared states and constants for the stopwatch front panel
package stop_watch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LAP    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam logic [3:0]  DP_NORMAL         = 4'b0101;
  localparam logic [3:0]  DP_LAP            = 4'b1111;
  localparam logic [19:0] DB_CYCLES_DEFAULT = 20'd1000000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce counter and press pulse for one button
module btn_debounce
  import stop_watch_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic press_pulse
);

  logic        sync1, sync2;
  logic        level_prev;
  logic        armed;
  logic [19:0] cnt;

  // Synchronizer is left unreset so a button held through reset is still seen as held.
  always_ff @(posedge clk) begin
    sync1 <= btn_in;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_out   <= 1'b0;
      level_prev  <= 1'b0;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
      cnt         <= 20'd0;
    end else begin
      level_prev  <= level_out;
      press_pulse <= armed & level_out & ~level_prev;
      // A press only counts once the button has been seen released since reset.
      if (!sync2 && !level_out) armed <= 1'b1;
      if (sync2 != level_out) begin
        if (cnt == DB_CYCLES - 20'd1) begin
          level_out <= sync2;
          cnt       <= 20'd0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= 20'd0;
      end
    end
  end

endmodule

// File: rtl/stop_watch_ctrl.sv
// rtl/stop_watch_ctrl.sv - stopwatch button debounce, mode FSM and display/counter control
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic [15:0] MAX_BCD   = 16'h9999,
  parameter logic        AUTO_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [15:0] cur_bcd,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [15:0] disp_bcd,
  output logic [3:0]  dp_out,
  output logic        lap_led
);

  logic        start_p, lap_p, clear_p;
  logic [2:0]  level_unused;
  state_t      state, next_state;
  logic [15:0] lap_reg, lap_next;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .btn_in(btn_start),
    .level_out(level_unused[0]), .press_pulse(start_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .btn_in(btn_lap),
    .level_out(level_unused[1]), .press_pulse(lap_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk), .reset(reset), .btn_in(btn_clear),
    .level_out(level_unused[2]), .press_pulse(clear_p)
  );

  // Only the highest-priority pulse is considered, even if that state ignores it.
  always_comb begin
    next_state = state;
    lap_next   = lap_reg;
    if (clear_p) begin
      if (state == PAUSED) next_state = IDLE;
    end else if (start_p) begin
      next_state = (state == RUN || state == LAP) ? PAUSED : RUN;
    end else if (lap_p) begin
      if (state == RUN) begin
        next_state = LAP;
        lap_next   = cur_bcd;
      end else if (state == LAP) begin
        next_state = RUN;
      end
    end else if (AUTO_STOP && (state == RUN || state == LAP) && cur_bcd == MAX_BCD) begin
      next_state = PAUSED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lap_reg  <= 16'h0000;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b1;
      disp_bcd <= 16'h0000;
      dp_out   <= DP_NORMAL;
      lap_led  <= 1'b0;
    end else begin
      state    <= next_state;
      lap_reg  <= lap_next;
      cnt_en   <= (next_state == RUN) || (next_state == LAP);
      cnt_clr  <= (next_state == IDLE);
      lap_led  <= (next_state == LAP);
      dp_out   <= (next_state == LAP) ? DP_LAP : DP_NORMAL;
      disp_bcd <= (next_state == LAP) ? lap_next : cur_bcd;
    end
  end

endmodule
